// File: rtl/cmd_pkg.sv
// Shared command/response types for the host link.
// Packet layouts, opcodes, status codes and serializer states.
package cmd_pkg;

    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] STAT_OK   = 8'h00;
    localparam logic [7:0] SYNC_MARK = 8'hA5;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_packet_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  status;
        logic [31:0] addr;
        logic [31:0] data;
    } rsp_packet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_OPC,
        ST_STAT,
        ST_ADDR,
        ST_DATA,
        ST_CSUM
    } rsp_state_e;

    // Byte of a 32-bit word, index 0 selects the most significant byte.
    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rsp_serializer.sv
// Response packet to byte-stream framer.
// Emits SYNC, header, optional data and an XOR checksum.
module rsp_serializer
    import cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = cmd_pkg::SYNC_MARK,
    parameter logic [7:0] OP_READ   = cmd_pkg::OP_READ,
    parameter logic [7:0] STAT_OK   = cmd_pkg::STAT_OK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_fifo_valid,
    input  rsp_packet_t rsp_fifo_data,
    output logic        rsp_fifo_rd_en,
    input  logic        tx_fifo_full,
    output logic        tx_fifo_wr_en,
    output logic [7:0]  tx_fifo_wr_data,
    output logic        busy
);

    rsp_state_e  state_q, state_d;
    rsp_packet_t pkt_q, pkt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic        armed_q;
    logic [7:0]  byte_c;
    logic        has_data;

    assign has_data = (pkt_q.opcode == OP_READ) &&
                      (pkt_q.status == STAT_OK);

    // State, latched packet, byte index and checksum registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pkt_q   <= '0;
            idx_q   <= 2'd0;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    // Blocks a pop on the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // Byte mux: depends only on held state, so it is stable under stall.
    always_comb begin
        byte_c = 8'h00;
        unique case (state_q)
            ST_SYNC: byte_c = SYNC_BYTE;
            ST_OPC:  byte_c = pkt_q.opcode;
            ST_STAT: byte_c = pkt_q.status;
            ST_ADDR: byte_c = word_byte(pkt_q.addr, idx_q);
            ST_DATA: byte_c = word_byte(pkt_q.data, idx_q);
            ST_CSUM: byte_c = csum_q;
            default: byte_c = 8'h00;
        endcase
    end

    // Next-state, pop/write strobes and checksum accumulation.
    always_comb begin
        state_d        = state_q;
        pkt_d          = pkt_q;
        idx_d          = idx_q;
        csum_d         = csum_q;
        rsp_fifo_rd_en = 1'b0;
        tx_fifo_wr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rsp_fifo_valid && armed_q) begin
                    rsp_fifo_rd_en = 1'b1;
                    pkt_d          = rsp_fifo_data;
                    csum_d         = 8'h00;
                    idx_d          = 2'd0;
                    state_d        = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    state_d       = ST_OPC;
                end
            end
            ST_OPC: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    csum_d        = csum_q ^ byte_c;
                    state_d       = ST_STAT;
                end
            end
            ST_STAT: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    csum_d        = csum_q ^ byte_c;
                    state_d       = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    csum_d        = csum_q ^ byte_c;
                    idx_d         = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = has_data ? ST_DATA : ST_CSUM;
                    end
                end
            end
            ST_DATA: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    csum_d        = csum_q ^ byte_c;
                    idx_d         = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_fifo_wr_data = byte_c;
    assign busy = (state_q != ST_IDLE) | rsp_fifo_rd_en;

endmodule

// File: tb/tb_rsp_serializer.sv
// Directed bench for rsp_serializer.
// Vector table plus stall, back-to-back and mid-frame reset sequences.
module tb_rsp_serializer;
    import cmd_pkg::*;

    logic        clk;
    logic        rst;
    logic        rsp_fifo_valid;
    rsp_packet_t rsp_fifo_data;
    logic        rsp_fifo_rd_en;
    logic        tx_fifo_full;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_wr_data;
    logic        busy;

    rsp_serializer dut (
        .clk             (clk),
        .rst             (rst),
        .rsp_fifo_valid  (rsp_fifo_valid),
        .rsp_fifo_data   (rsp_fifo_data),
        .rsp_fifo_rd_en  (rsp_fifo_rd_en),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_wr_en   (tx_fifo_wr_en),
        .tx_fifo_wr_data (tx_fifo_wr_data),
        .busy            (busy)
    );

    typedef struct {
        rsp_packet_t pkt;
        int          nb;
        logic [95:0] exp;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    rsp_packet_t mem [16];
    int head = 0;
    int tail = 0;

    logic [7:0] byte_q [$];
    int         cyc_q  [$];
    int         pop_cyc[$];

    int   stall_at   = 0;
    int   stall_left = 0;
    logic hold_chk   = 1'b0;
    int   stall_seen = 0;

    vec_t vt [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_fifo_wr_en) begin
            byte_q.push_back(tx_fifo_wr_data);
            cyc_q.push_back(cyc);
            check("busy_on_write", {31'd0, busy}, 32'd1);
        end
        if (rsp_fifo_rd_en) begin
            pop_cyc.push_back(cyc);
            head++;
        end
        if (hold_chk && tx_fifo_full) begin
            stall_seen++;
            check("stall_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
            check("stall_hold_data", {24'd0, tx_fifo_wr_data}, 32'h10);
        end
    end

    task automatic upd_inputs();
        rsp_fifo_valid = (head < tail);
        if (head < tail) rsp_fifo_data = mem[head];
        else rsp_fifo_data = {$urandom, $urandom, 16'($urandom)};
        if (stall_left > 0 && byte_q.size() >= stall_at) begin
            tx_fifo_full = 1'b1;
            stall_left--;
        end else begin
            tx_fifo_full = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        upd_inputs();
    endtask

    task automatic push(input rsp_packet_t p);
        mem[tail] = p;
        tail++;
        upd_inputs();
    endtask

    task automatic clear_logs();
        byte_q.delete();
        cyc_q.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (byte_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (byte_q.size() < n) check("timeout_bytes", byte_q.size(), n);
    endtask

    task automatic cmp_frame(input string tag, input int base,
                             input int nb, input logic [95:0] exp);
        logic [7:0] got;
        for (int i = 0; i < nb; i++) begin
            got = (base + i < byte_q.size()) ? byte_q[base+i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i),
                  {24'd0, got}, {24'd0, exp[95-8*i -: 8]});
        end
    endtask

    initial begin
        vt[0] = '{rsp_packet_t'{8'h52, 8'h00, 32'h0000_1000, 32'hDEAD_BEEF},
                  12, 96'hA5_52_00_00_00_10_00_DE_AD_BE_EF_60};
        vt[1] = '{rsp_packet_t'{8'h57, 8'h00, 32'h0000_0004, 32'h1122_3344},
                  8, {64'hA5_57_00_00_00_00_04_53, 32'h0}};
        vt[2] = '{rsp_packet_t'{8'h52, 8'h01, 32'h0000_1000, 32'hDEAD_BEEF},
                  8, {64'hA5_52_01_00_00_10_00_43, 32'h0}};
        vt[3] = '{rsp_packet_t'{8'h52, 8'h00, 32'hFFFF_FFFF, 32'h0123_4567},
                  12, 96'hA5_52_00_FF_FF_FF_FF_01_23_45_67_52};
        vt[4] = '{rsp_packet_t'{8'h53, 8'h00, 32'h1234_5678, 32'hCAFE_F00D},
                  8, {64'hA5_53_00_12_34_56_78_5B, 32'h0}};

        rst = 1'b0;
        rsp_fifo_valid = 1'b0;
        rsp_fifo_data = '0;
        tx_fifo_full = 1'b0;
        repeat (2) tick();
        check("rst_rd_en", {31'd0, rsp_fifo_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
        check("rst_wr_data", {24'd0, tx_fifo_wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            push(vt[v].pkt);
            wait_bytes(vt[v].nb, 80);
            repeat (3) tick();
            cmp_frame($sformatf("vec%0d", v), 0, vt[v].nb, vt[v].exp);
            check($sformatf("vec%0d_len", v), byte_q.size(), vt[v].nb);
            check($sformatf("vec%0d_pops", v), pop_cyc.size(), 1);
            if (cyc_q.size() == vt[v].nb && pop_cyc.size() == 1) begin
                check($sformatf("vec%0d_span", v),
                      cyc_q[vt[v].nb-1] - cyc_q[0], vt[v].nb - 1);
                check($sformatf("vec%0d_latency", v),
                      cyc_q[0] - pop_cyc[0], 1);
            end
            check($sformatf("vec%0d_busy_end", v), {31'd0, busy}, 32'd0);
        end

        clear_logs();
        stall_seen = 0;
        stall_at   = 5;
        stall_left = 3;
        hold_chk   = 1'b1;
        push(vt[0].pkt);
        wait_bytes(12, 80);
        repeat (3) tick();
        hold_chk = 1'b0;
        cmp_frame("stall", 0, 12, vt[0].exp);
        check("stall_len", byte_q.size(), 12);
        check("stall_cycles", stall_seen, 3);
        check("stall_pops", pop_cyc.size(), 1);
        if (cyc_q.size() == 12) check("stall_span", cyc_q[11] - cyc_q[0], 14);

        clear_logs();
        push(vt[1].pkt);
        push(vt[2].pkt);
        wait_bytes(16, 100);
        repeat (3) tick();
        cmp_frame("b2b_a", 0, 8, vt[1].exp);
        cmp_frame("b2b_b", 8, 8, vt[2].exp);
        check("b2b_len", byte_q.size(), 16);
        check("b2b_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2 && cyc_q.size() == 16) begin
            check("b2b_gap", pop_cyc[1] - cyc_q[7], 1);
            check("b2b_latency", cyc_q[8] - pop_cyc[1], 1);
        end

        clear_logs();
        push(vt[0].pkt);
        push(vt[1].pkt);
        wait_bytes(8, 80);
        rst = 1'b0;
        #1;
        check("mrst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
        check("mrst_rd_en", {31'd0, rsp_fifo_rd_en}, 32'd0);
        check("mrst_wr_data", {24'd0, tx_fifo_wr_data}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("mrst_no_bytes", byte_q.size(), 8);
        check("mrst_no_pop", pop_cyc.size(), 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rel_no_pop", {31'd0, rsp_fifo_rd_en}, 32'd0);
        wait_bytes(16, 80);
        repeat (3) tick();
        cmp_frame("mrst_new", 8, 8, vt[1].exp);
        check("mrst_len", byte_q.size(), 16);
        check("mrst_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2 && cyc_q.size() == 16) begin
            check("mrst_latency", cyc_q[8] - pop_cyc[1], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rsp_serializer.md
RSP_SERIALIZER -- requirements
Module: rsp_serializer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter OP_READ, default 8'h52: opcode whose OK response carries data.
REQ-003 Parameter STAT_OK, default 8'h00: success status code.
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 rsp_fifo_valid  in  1  response FIFO non-empty; rsp_fifo_data valid (first-word-fall-through).
REQ-008 rsp_fifo_data  in  rsp_packet_t  {opcode[7:0], status[7:0], addr[31:0], data[31:0]}.
REQ-009 rsp_fifo_rd_en  out  1  single-cycle pop of the response FIFO.
REQ-010 tx_fifo_full  in  1  TX byte FIFO cannot accept a write this cycle.
REQ-011 tx_fifo_wr_en  out  1  byte write strobe toward the TX byte FIFO / uart_tx.
REQ-012 tx_fifo_wr_data  out  8  byte written when tx_fifo_wr_en=1.
REQ-013 busy  out  1  high from pop until the checksum byte is written.

Function
REQ-014 Frame SHALL be: SYNC, opcode, status, addr[31:24], addr[23:16], addr[15:8], addr[7:0], [data MSB-first, 4 bytes], checksum.
REQ-015 Data bytes SHALL be included only when opcode==OP_READ and status==STAT_OK; otherwise omitted.
REQ-016 Checksum SHALL be the 8-bit XOR of all emitted bytes after SYNC, excluding SYNC and the checksum itself.
REQ-017 States SHALL be IDLE, SYNC, OPC, STAT, ADDR, DATA, CSUM.
REQ-018 IDLE: when rsp_fifo_valid=1, assert rsp_fifo_rd_en for one cycle, latch rsp_fifo_data that cycle, clear checksum, go to SYNC.
REQ-019 Each emitting state SHALL drive tx_fifo_wr_en=1 only when tx_fifo_full=0, advancing one byte per accepted write.
REQ-020 When tx_fifo_full=1, the state, byte index, and tx_fifo_wr_data SHALL hold, with tx_fifo_wr_en=0.
REQ-021 ADDR and DATA SHALL use a 2-bit byte index counting 0..3; they exit after index 3 is accepted, with the index wrapping to 0.
REQ-022 Transitions: SYNC->OPC->STAT->ADDR->(DATA if REQ-015 holds, else CSUM); DATA->CSUM; CSUM->IDLE.
REQ-023 Latency: first byte (SYNC) SHALL be written the cycle after the pop, given no backpressure.
REQ-024 Back-to-back: a new pop SHALL occur no earlier than the cycle after the CSUM write, giving exactly one idle cycle between frames.
REQ-025 rsp_fifo_rd_en SHALL never assert outside IDLE, even if rsp_fifo_valid=1.
REQ-026 Changes on rsp_fifo_data after the pop SHALL NOT affect the frame in progress.

Reset
REQ-027 On rst=0, the block SHALL enter IDLE and clear rsp_fifo_rd_en, tx_fifo_wr_en, tx_fifo_wr_data, busy, the byte index, and the checksum, all to 0, immediately (asynchronously).
REQ-028 Reset mid-frame SHALL abandon the frame with no further bytes written, and no pop SHALL occur on the first clock edge after reset release.

Structure
REQ-029 rsp_packet_t, OP_READ/OP_WRITE (8'h57), and STAT_OK SHALL live in cmd_pkg alongside cmd_packet_t.
REQ-030 There SHALL be no sub-module; the FSM, byte mux, and checksum accumulator are a single module.

Verification
REQ-031 Read OK, opcode 52, status 00, addr 0x00001000, data 0xDEADBEEF -> bytes A5 52 00 00 00 10 00 DE AD BE EF 60, in 12 consecutive cycles.
REQ-032 Write OK, opcode 57, status 00, addr 0x00000004 -> A5 57 00 00 00 00 04 53; no data bytes.
REQ-033 Read error, opcode 52, status 01, addr 0x00001000 -> A5 52 01 00 00 10 00 43; data suppressed.
REQ-034 The REQ-031 packet with tx_fifo_full=1 for 3 cycles at byte addr[15:8] -> the same 12-byte stream, no duplicate or lost byte, and tx_fifo_wr_data held at 10 throughout the stall.
REQ-035 Two queued packets (REQ-032 then REQ-033) -> two frames, a second pop exactly one cycle after the first CSUM write, and exactly 2 pops total.
REQ-036 rst low during the DATA state of REQ-031 -> outputs 0 at once, no further writes, and the next queued packet yields a complete fresh frame starting with A5.
